// File: rtl/spasarb_10.sv
// Two-requester round-robin arbiter plus burst address sequencer for a shared
// memory address register. The winner's start address is loaded, then stepped once per accepted beat.
module spasarb_10 #(
  parameter int AW = 10,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [LW-1:0] len0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [LW-1:0] len1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          owner,
  output logic [AW-1:0] mem_addr,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic          mem_last,
  output logic          busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  logic          ptr;
  logic [LW-1:0] cnt;
  logic          win;

  // Under contention the pointer decides; otherwise whoever is asking wins.
  assign win      = (req0 && req1) ? ptr : req1;
  assign mem_last = mem_valid && (cnt == '0);
  assign busy     = (state == BURST);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cnt       <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      owner     <= 1'b0;
      mem_addr  <= '0;
      mem_valid <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state     <= BURST;
            gnt0      <= ~win;
            gnt1      <= win;
            owner     <= win;
            mem_addr  <= win ? addr1 : addr0;
            cnt       <= win ? len1 : len0;
            mem_valid <= 1'b1;
          end
        end
        BURST: begin
          if (mem_valid && mem_ready) begin
            if (cnt == '0) begin
              state     <= IDLE;
              mem_valid <= 1'b0;
              ptr       <= ~owner;
            end else begin
              mem_addr <= mem_addr + 1'b1;
              cnt      <= cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
